// File: rtl/coherence_bus_ctrl.sv
// Two-core snoopy coherence bus: arbitrates one RAM port among icaches/dcaches and sequences snoops.
// Define COH_STATS_EN to add the snoop_hits / snoop_total saturating counters.
module coherence_bus_ctrl #(
  parameter int CPUS      = 2,
  parameter int SNOOP_CYC = 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [CPUS-1:0]       iREN,
  input  logic [CPUS-1:0][31:0] iaddr,
  output logic [CPUS-1:0]       iwait,
  output logic [CPUS-1:0][31:0] iload,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0]       dwait,
  output logic [CPUS-1:0][31:0] dload,
  input  logic [CPUS-1:0]       cctrans,
  input  logic [CPUS-1:0]       ccwrite,
  output logic [CPUS-1:0]       ccwait,
  output logic [CPUS-1:0]       ccinv,
  output logic [CPUS-1:0][31:0] ccsnoopaddr,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  input  logic [31:0]           ramload,
  input  logic [1:0]            ramstate
`ifdef COH_STATS_EN
  ,
  output logic [31:0]           snoop_hits,
  output logic [31:0]           snoop_total
`endif
);

  localparam int CW = (SNOOP_CYC > 1) ? $clog2(SNOOP_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SNOOP_CYC - 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [2:0] {IDLE, SNOOP, SUP1, SUP2, LD1, LD2, WB, IFETCH} state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic          req, next_req;
  logic [31:3]   blk, next_blk;
  logic          inv, next_inv;
  logic          rr_d, next_rr_d;
  logic          rr_i, next_rr_i;

  logic            peer, access, snoop_end, peer_dirty, gnt;
  logic [CPUS-1:0] coh_req, wb_req;

  assign peer       = ~req;
  assign access     = (ramstate == RAM_ACCESS);
  assign coh_req    = dREN & cctrans;
  assign wb_req     = dWEN & ~cctrans;
  assign snoop_end  = (state == SNOOP) && (cnt == CNT_LAST);
  assign peer_dirty = cctrans[peer] & ccwrite[peer];

  // Round-robin pick: a lone requester wins, a tie goes to the core the rr bit points at.
  function automatic logic pick(input logic [CPUS-1:0] v, input logic pri);
    return (v == 2'b11) ? pri : v[1];
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
      req   <= 1'b0;
      blk   <= '0;
      inv   <= 1'b0;
      rr_d  <= 1'b0;
      rr_i  <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      req   <= next_req;
      blk   <= next_blk;
      inv   <= next_inv;
      rr_d  <= next_rr_d;
      rr_i  <= next_rr_i;
    end
  end

  always_comb begin
    next_state  = state;
    next_cnt    = cnt;
    next_req    = req;
    next_blk    = blk;
    next_inv    = inv;
    next_rr_d   = rr_d;
    next_rr_i   = rr_i;
    gnt         = 1'b0;
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state)
      IDLE: begin
        if (|coh_req) begin
          gnt        = pick(coh_req, rr_d);
          next_req   = gnt;
          next_blk   = daddr[gnt][31:3];
          next_inv   = ccwrite[gnt];
          next_cnt   = '0;
          next_state = SNOOP;
        end else if (|wb_req) begin
          gnt        = pick(wb_req, rr_d);
          next_req   = gnt;
          next_state = WB;
        end else if (|iREN) begin
          gnt        = pick(iREN, rr_i);
          next_req   = gnt;
          next_state = IFETCH;
        end
      end
      SNOOP: begin
        ccwait[peer]      = 1'b1;
        ccsnoopaddr[peer] = {blk, 3'b000};
        ccinv[peer]       = inv;
        if (snoop_end) next_state = peer_dirty ? SUP1 : LD1;
        else           next_cnt   = cnt + 1'b1;
      end
      // Peer's dirty word goes to the requester and to RAM in the same transfer.
      SUP1, SUP2: begin
        ccwait[peer]      = 1'b1;
        ccsnoopaddr[peer] = {blk, 3'b000};
        ccinv[peer]       = inv;
        ramWEN            = 1'b1;
        ramaddr           = daddr[peer];
        ramstore          = dstore[peer];
        dload[req]        = dstore[peer];
        if (access) begin
          dwait[req]  = ~dREN[req];
          dwait[peer] = 1'b0;
          if (state == SUP1) begin
            next_state = SUP2;
          end else begin
            next_state = IDLE;
            next_rr_d  = peer;
          end
        end
      end
      LD1, LD2: begin
        ramREN     = 1'b1;
        ramaddr    = daddr[req];
        dload[req] = ramload;
        if (access) begin
          dwait[req] = ~dREN[req];
          if (state == LD1) begin
            next_state = LD2;
          end else begin
            next_state = IDLE;
            next_rr_d  = peer;
          end
        end
      end
      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[req];
        ramstore = dstore[req];
        if (access) begin
          dwait[req] = 1'b0;
          next_state = IDLE;
          next_rr_d  = peer;
        end
      end
      IFETCH: begin
        ramREN     = 1'b1;
        ramaddr    = iaddr[req];
        iload[req] = ramload;
        if (access) begin
          iwait[req] = 1'b0;
          next_state = IDLE;
          next_rr_i  = peer;
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef COH_STATS_EN
  // Every snoop resolution counts toward the total; dirty hits also count as hits.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      snoop_hits  <= '0;
      snoop_total <= '0;
    end else if (snoop_end) begin
      if (snoop_total != 32'hFFFF_FFFF) snoop_total <= snoop_total + 32'd1;
      if (peer_dirty && (snoop_hits != 32'hFFFF_FFFF)) snoop_hits <= snoop_hits + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: a transaction-level model is compared every cycle,
// and scenario checks pin hand-computed values.
module tb_coherence_bus_ctrl;

  localparam int SNOOP_CYC = 1;
  localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACCESS = 2'd2, R_ERROR = 2'd3;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       iREN, dREN, dWEN, cctrans, ccwrite;
  logic [1:0][31:0] iaddr, daddr, dstore;
  logic [1:0]       iwait, dwait, ccwait, ccinv;
  logic [1:0][31:0] iload, dload, ccsnoopaddr;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;
`ifdef COH_STATS_EN
  logic [31:0]      snoop_hits, snoop_total;
`endif

  int compared   = 0;
  int mismatched = 0;
  bit check_en   = 1'b0;

  coherence_bus_ctrl #(.CPUS(2), .SNOOP_CYC(SNOOP_CYC)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef COH_STATS_EN
    , .snoop_hits(snoop_hits), .snoop_total(snoop_total)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: one outstanding transaction described by kind, owner, snoop cycles left and words left.
  typedef enum {T_NONE, T_COH, T_WB, T_IF} kind_t;
  typedef struct {
    kind_t     kind;
    bit        core;
    bit [31:0] blk;
    bit        inv;
    int        snoop_left;
    bit        dirty;
    int        words_left;
    bit        rr_d;
    bit        rr_i;
    bit [31:0] hits;
    bit [31:0] total;
  } model_t;
  model_t m;

  function automatic bit choose(input logic [1:0] v, input bit pri);
    if (v[0] && v[1]) return pri;
    return v[1] ? 1'b1 : 1'b0;
  endfunction

  always @(posedge CLK or negedge nRST) begin : model_proc
    model_t     n;
    bit         acc, p;
    logic [1:0] coh, wb;
    if (!nRST) begin
      n.kind = T_NONE; n.core = 0; n.blk = 0; n.inv = 0; n.snoop_left = 0; n.dirty = 0;
      n.words_left = 0; n.rr_d = 0; n.rr_i = 0; n.hits = 0; n.total = 0;
    end else begin
      n   = m;
      acc = (ramstate == R_ACCESS);
      p   = !m.core;
      coh = dREN & cctrans;
      wb  = dWEN & ~cctrans;
      case (m.kind)
        T_NONE: begin
          if (coh != 2'b00) begin
            n.kind = T_COH; n.core = choose(coh, m.rr_d);
            n.blk = daddr[n.core] & 32'hFFFF_FFF8; n.inv = ccwrite[n.core];
            n.snoop_left = SNOOP_CYC; n.dirty = 0; n.words_left = 2;
          end else if (wb != 2'b00) begin
            n.kind = T_WB; n.core = choose(wb, m.rr_d); n.words_left = 1;
          end else if (iREN != 2'b00) begin
            n.kind = T_IF; n.core = choose(iREN, m.rr_i); n.words_left = 1;
          end
        end
        T_COH: begin
          if (m.snoop_left > 0) begin
            n.snoop_left = m.snoop_left - 1;
            if (n.snoop_left == 0) begin
              n.dirty = cctrans[p] & ccwrite[p];
              if (m.total != 32'hFFFF_FFFF) n.total = m.total + 1;
              if (n.dirty && m.hits != 32'hFFFF_FFFF) n.hits = m.hits + 1;
            end
          end else if (acc) begin
            n.words_left = m.words_left - 1;
            if (n.words_left == 0) begin n.kind = T_NONE; n.rr_d = p; end
          end
        end
        default: begin
          if (acc) begin
            n.kind = T_NONE;
            if (m.kind == T_WB) n.rr_d = p;
            else                n.rr_i = p;
          end
        end
      endcase
    end
    m <= n;
  end

  always @(negedge CLK) begin : compare_proc
    logic [1:0]       e_iwait, e_dwait, e_ccwait, e_ccinv;
    logic [1:0][31:0] e_iload, e_dload, e_snoop;
    logic             e_ren, e_wen;
    logic [31:0]      e_addr, e_store;
    bit               g, p, acc;
    if (check_en) begin
      e_iwait = 2'b11; e_dwait = 2'b11; e_ccwait = 0; e_ccinv = 0;
      e_iload = 0; e_dload = 0; e_snoop = 0; e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
      g = m.core; p = !m.core; acc = (ramstate == R_ACCESS);
      case (m.kind)
        T_COH: begin
          if (m.snoop_left > 0 || m.dirty) begin
            e_ccwait[p] = 1; e_snoop[p] = m.blk; e_ccinv[p] = m.inv;
          end
          if (m.snoop_left == 0 && m.dirty) begin
            e_wen = 1; e_addr = daddr[p]; e_store = dstore[p]; e_dload[g] = dstore[p];
            if (acc) begin e_dwait[g] = !dREN[g]; e_dwait[p] = 0; end
          end else if (m.snoop_left == 0) begin
            e_ren = 1; e_addr = daddr[g]; e_dload[g] = ramload;
            if (acc) e_dwait[g] = !dREN[g];
          end
        end
        T_WB: begin
          e_wen = 1; e_addr = daddr[g]; e_store = dstore[g];
          if (acc) e_dwait[g] = 0;
        end
        T_IF: begin
          e_ren = 1; e_addr = iaddr[g]; e_iload[g] = ramload;
          if (acc) e_iwait[g] = 0;
        end
        default: ;
      endcase
      checkOutput("cyc_iwait", iwait, e_iwait);
      checkOutput("cyc_iload", iload, e_iload);
      checkOutput("cyc_dwait", dwait, e_dwait);
      checkOutput("cyc_dload", dload, e_dload);
      checkOutput("cyc_ccwait", ccwait, e_ccwait);
      checkOutput("cyc_ccinv", ccinv, e_ccinv);
      checkOutput("cyc_ccsnoopaddr", ccsnoopaddr, e_snoop);
      checkOutput("cyc_ramREN", ramREN, e_ren);
      checkOutput("cyc_ramWEN", ramWEN, e_wen);
      checkOutput("cyc_ramaddr", ramaddr, e_addr);
      checkOutput("cyc_ramstore", ramstore, e_store);
`ifdef COH_STATS_EN
      checkOutput("cyc_snoop_hits", snoop_hits, m.hits);
      checkOutput("cyc_snoop_total", snoop_total, m.total);
`endif
    end
  end

  // Advance to just after the next rising edge, then drive one cycle's inputs.
  task automatic applyStimulus(input logic [1:0] i_ren, input logic [1:0] d_ren,
                               input logic [1:0] d_wen, input logic [1:0] cct,
                               input logic [1:0] ccw, input logic [1:0] rs, input logic [31:0] rl);
    @(posedge CLK);
    #1;
    iREN = i_ren; dREN = d_ren; dWEN = d_wen; cctrans = cct; ccwrite = ccw;
    ramstate = rs; ramload = rl;
  endtask

  logic [1:0] s1_rs [6] = '{R_FREE, R_BUSY, R_BUSY, R_ACCESS, R_FREE, R_FREE};

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          ren_cnt, iw_low, both_low;
    logic [31:0] got;
    iREN = 0; dREN = 0; dWEN = 0; cctrans = 0; ccwrite = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramstate = R_FREE; ramload = 0;
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    check_en = 1'b1;

    @(negedge CLK);
    checkOutput("reset_iwait", iwait, 2'b11);
    checkOutput("reset_dwait", dwait, 2'b11);
    checkOutput("reset_ram", {ramREN, ramWEN, ramaddr}, 34'h0);

    // Ifetch with two BUSY cycles before ACCESS.
    ren_cnt = 0; iw_low = 0; got = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus((c < 4) ? 2'b01 : 2'b00, 0, 0, 0, 0, s1_rs[c], (c == 3) ? 32'h2402000A : 32'h0);
      if (c == 0) iaddr[0] = 32'h40;
      @(negedge CLK);
      if (ramREN) ren_cnt++;
      if (!iwait[0]) begin iw_low++; got = iload[0]; end
    end
    checkOutput("if_ramREN_cycles", ren_cnt, 3);
    checkOutput("if_iwait_low", iw_low, 1);
    checkOutput("if_iload", got, 32'h2402000A);

    // Core0 read miss, core1 clean.
    applyStimulus(0, 2'b01, 0, 2'b01, 0, R_FREE, 0); daddr[0] = 32'h100;
    applyStimulus(0, 2'b01, 0, 2'b01, 0, R_FREE, 0);
    @(negedge CLK);
    checkOutput("rd_ccwait", ccwait, 2'b10);
    checkOutput("rd_snoopaddr", ccsnoopaddr[1], 32'h100);
    checkOutput("rd_ccinv", ccinv, 2'b00);
    applyStimulus(0, 2'b01, 0, 2'b01, 0, R_ACCESS, 32'h11);
    @(negedge CLK);
    checkOutput("rd_w0_dwait", dwait, 2'b10);
    checkOutput("rd_w0_addr", ramaddr, 32'h100);
    checkOutput("rd_w0_dload", dload[0], 32'h11);
    applyStimulus(0, 2'b01, 0, 2'b01, 0, R_ACCESS, 32'h22); daddr[0] = 32'h104;
    @(negedge CLK);
    checkOutput("rd_w1_dwait", dwait, 2'b10);
    checkOutput("rd_w1_addr", ramaddr, 32'h104);
    checkOutput("rd_w1_ccwait", ccwait, 2'b00);
    applyStimulus(0, 0, 0, 0, 0, R_FREE, 0);
    @(negedge CLK);
    checkOutput("rd_done_dwait", dwait, 2'b11);

    // Core1 write miss, core0 supplies dirty block (one ERROR cycle first).
    applyStimulus(0, 2'b10, 0, 2'b10, 2'b10, R_FREE, 0); daddr[1] = 32'h204;
    applyStimulus(0, 2'b10, 2'b01, 2'b11, 2'b11, R_FREE, 0);
    daddr[0] = 32'h200; dstore[0] = 32'hDEAD;
    @(negedge CLK);
    checkOutput("wr_ccinv", ccinv, 2'b01);
    checkOutput("wr_snoopaddr", ccsnoopaddr[0], 32'h200);
    both_low = 0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 2'b10, 2'b01, 2'b11, 2'b11, (c == 0) ? R_ERROR : R_ACCESS, 0);
      if (c == 2) begin daddr[0] = 32'h204; dstore[0] = 32'hBEEF; end
      @(negedge CLK);
      if (dwait == 2'b00) both_low++;
      if (c == 1) checkOutput("wr_w0", {dload[1], ramaddr}, {32'hDEAD, 32'h200});
      if (c == 2) checkOutput("wr_w1", {dload[1], ramaddr}, {32'hBEEF, 32'h204});
    end
    checkOutput("wr_both_low", both_low, 2);
    applyStimulus(0, 0, 0, 0, 0, R_FREE, 0);
    @(negedge CLK);
    checkOutput("wr_done_ccwait", ccwait, 2'b00);
`ifdef COH_STATS_EN
    checkOutput("stats_after_wr", {snoop_hits, snoop_total}, {32'd1, 32'd2});
`endif

    // Both cores miss together: core0 first, then core1, then a second tie goes to core0 again.
    applyStimulus(0, 2'b11, 0, 2'b11, 0, R_FREE, 0); daddr[0] = 32'h300; daddr[1] = 32'h308;
    applyStimulus(0, 2'b11, 0, 2'b11, 0, R_FREE, 0);
    @(negedge CLK);
    checkOutput("tie1_ccwait", ccwait, 2'b10);
    applyStimulus(0, 2'b11, 0, 2'b11, 0, R_ACCESS, 32'h31);
    applyStimulus(0, 2'b11, 0, 2'b11, 0, R_ACCESS, 32'h32); daddr[0] = 32'h304;
    applyStimulus(0, 2'b10, 0, 2'b10, 0, R_FREE, 0);
    applyStimulus(0, 2'b10, 0, 2'b10, 0, R_FREE, 0);
    @(negedge CLK);
    checkOutput("tie2_ccwait", ccwait, 2'b01);
    checkOutput("tie2_snoopaddr", ccsnoopaddr[0], 32'h308);
    applyStimulus(0, 2'b10, 0, 2'b10, 0, R_ACCESS, 32'h33);
    applyStimulus(0, 2'b10, 0, 2'b10, 0, R_ACCESS, 32'h34); daddr[1] = 32'h30C;
    applyStimulus(0, 2'b11, 0, 2'b11, 0, R_FREE, 0); daddr[0] = 32'h340; daddr[1] = 32'h348;
    applyStimulus(0, 2'b11, 0, 2'b11, 0, R_FREE, 0);
    @(negedge CLK);
    checkOutput("tie3_ccwait", ccwait, 2'b10);
    applyStimulus(0, 2'b11, 0, 2'b11, 0, R_ACCESS, 32'h41);
    applyStimulus(0, 2'b11, 0, 2'b11, 0, R_ACCESS, 32'h42);

    // Reset asserted during LD2.
    #1 nRST = 1'b0;
    #1;
    checkOutput("rst_waits", {iwait, dwait, ccwait, ccinv}, 8'hF0);
    checkOutput("rst_ram", {ramREN, ramWEN, ramaddr, ramstore}, 66'h0);
    checkOutput("rst_loads", {dload, iload}, 128'h0);
`ifdef COH_STATS_EN
    checkOutput("rst_stats", {snoop_hits, snoop_total}, 64'h0);
`endif
    applyStimulus(0, 0, 0, 0, 0, R_FREE, 0);
    nRST = 1'b1;

    // Ifetch and plain writeback pending together: writeback wins.
    applyStimulus(2'b01, 0, 2'b10, 0, 0, R_FREE, 0);
    iaddr[0] = 32'h80; daddr[1] = 32'h400; dstore[1] = 32'h55;
    applyStimulus(2'b01, 0, 2'b10, 0, 0, R_ACCESS, 0);
    @(negedge CLK);
    checkOutput("wb_ram", {ramREN, ramWEN, ramaddr, ramstore}, {2'b01, 32'h400, 32'h55});
    checkOutput("wb_waits", {iwait, dwait}, 4'b1101);
    applyStimulus(2'b01, 0, 0, 0, 0, R_FREE, 0);
    applyStimulus(2'b01, 0, 0, 0, 0, R_ACCESS, 32'h77);
    @(negedge CLK);
    checkOutput("if2_iwait", iwait, 2'b10);
    checkOutput("if2_fetch", {ramaddr, iload[0]}, {32'h80, 32'h77});
    applyStimulus(0, 0, 0, 0, 0, R_FREE, 0);

    // Requester drops dREN mid-snoop: transaction finishes with no dwait pulse.
    applyStimulus(0, 2'b10, 0, 2'b10, 0, R_FREE, 0); daddr[1] = 32'h500;
    applyStimulus(0, 0, 0, 0, 0, R_FREE, 0);
    @(negedge CLK);
    checkOutput("drop_ccwait", ccwait, 2'b01);
    applyStimulus(0, 0, 0, 0, 0, R_ACCESS, 32'h51);
    @(negedge CLK);
    checkOutput("drop_dwait", dwait, 2'b11);
    checkOutput("drop_ramaddr", ramaddr, 32'h500);
    applyStimulus(0, 0, 0, 0, 0, R_ACCESS, 32'h52);
    applyStimulus(0, 0, 0, 0, 0, R_FREE, 0);
    @(negedge CLK);
    checkOutput("drop_idle_ramREN", ramREN, 1'b0);
`ifdef COH_STATS_EN
    checkOutput("stats_end", {snoop_hits, snoop_total}, {32'd0, 32'd1});
`endif

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
